// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: decodes the one-hot T-state ring and IR opcode into the
// 12-bit control word, and tracks halt, T-state sequence integrity and retired instructions.
module sap1_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       State,
  input  logic [3:0]       opcode,
  output logic [11:0]      con,
  output logic             hlt,
  output logic             state_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  // Control word bit positions
  localparam int unsigned CP = 11;
  localparam int unsigned EP = 10;
  localparam int unsigned LM = 9;
  localparam int unsigned CE = 8;
  localparam int unsigned LI = 7;
  localparam int unsigned EI = 6;
  localparam int unsigned LA = 5;
  localparam int unsigned EA = 4;
  localparam int unsigned SU = 3;
  localparam int unsigned EU = 2;
  localparam int unsigned LB = 1;
  localparam int unsigned LO = 0;

  logic       state_ok;
  logic [5:0] prev_state;
  logic       prev_valid;

  assign state_ok = $onehot(State);

  always_comb begin
    con = '0;
    case (State)
      T1: begin
        con[EP] = 1'b1;
        con[LM] = 1'b1;
      end
      T2: con[CP] = 1'b1;
      T3: begin
        con[CE] = 1'b1;
        con[LI] = 1'b1;
      end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            con[EI] = 1'b1;
            con[LM] = 1'b1;
          end
          OP_OUT: begin
            con[EA] = 1'b1;
            con[LO] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA: begin
            con[CE] = 1'b1;
            con[LA] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            con[CE] = 1'b1;
            con[LB] = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD: begin
            con[EU] = 1'b1;
            con[LA] = 1'b1;
          end
          OP_SUB: begin
            con[SU] = 1'b1;
            con[EU] = 1'b1;
            con[LA] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (clr || hlt || !state_ok) con = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hlt <= 1'b0;
    end else if (State == T4 && opcode == OP_HLT) begin
      hlt <= 1'b1;
    end
  end

  // The first State after clr has no predecessor, so only one-hotness is checked
  always_ff @(posedge clk) begin
    if (clr) begin
      prev_valid <= 1'b0;
      prev_state <= '0;
      state_err  <= 1'b0;
    end else begin
      if (!state_ok || (prev_valid && State != {prev_state[4:0], prev_state[5]}))
        state_err <= 1'b1;
      prev_state <= State;
      prev_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      instr_cnt <= '0;
    end else if (!hlt && State == T6 && instr_cnt != '1) begin
      instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller: fetch/execute control words, halt, sequence
// checker, and counter saturation/mid-instruction reset on a CNT_W=2 instance.
module tb_sap1_controller;

  logic        clk;
  logic        clr;
  logic [5:0]  State;
  logic [3:0]  opcode;
  logic [11:0] con, con2;
  logic        hlt, hlt2;
  logic        state_err, state_err2;
  logic [7:0]  instr_cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  sap1_controller #(.CNT_W(8)) dut (
    .clk(clk), .clr(clr), .State(State), .opcode(opcode),
    .con(con), .hlt(hlt), .state_err(state_err), .instr_cnt(instr_cnt)
  );

  sap1_controller #(.CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .State(State), .opcode(opcode),
    .con(con2), .hlt(hlt2), .state_err(state_err2), .instr_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  ring [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
  logic [11:0] lda_con [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
  logic [3:0]  alu_op [4] = '{4'b0001, 4'b0010, 4'b1110, 4'b0101};
  logic [11:0] alu_con [4][6] = '{
    '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024},
    '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C},
    '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000},
    '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000}
  };

  // Inputs change on negedge like the real ring; con is then sampled mid low-phase.
  task automatic drive(input logic [5:0] s, input logic [3:0] op, input logic c);
    @(negedge clk);
    State = s; opcode = op; clr = c;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(6'b000001, 4'b0000, 1'b1);
      checks++;
      if (con !== 12'h000) begin errors++; $display("FAIL reset_con: got %h expected %h", con, 12'h000); end
      tick;
      checks++;
      if ({hlt, state_err, instr_cnt} !== 10'd0) begin
        errors++; $display("FAIL reset_regs: got hlt=%b err=%b cnt=%0d expected 0 0 0", hlt, state_err, instr_cnt);
      end
      checks++;
      if ({hlt2, state_err2, cnt2} !== 4'd0) begin
        errors++; $display("FAIL reset_regs2: got hlt=%b err=%b cnt=%0d expected 0 0 0", hlt2, state_err2, cnt2);
      end
    end
  endtask

  task automatic test_lda;
    for (int i = 0; i < 6; i++) begin
      drive(ring[i], 4'b0000, 1'b0);
      checks++;
      if (con !== lda_con[i]) begin errors++; $display("FAIL lda_con_T%0d: got %h expected %h", i + 1, con, lda_con[i]); end
      tick;
      checks++;
      if (state_err !== 1'b0) begin errors++; $display("FAIL lda_err_T%0d: got %b expected 0", i + 1, state_err); end
    end
    checks++;
    if (instr_cnt !== 8'd1) begin errors++; $display("FAIL lda_cnt: got %0d expected 1", instr_cnt); end
  endtask

  task automatic test_alu_ops;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) begin
        drive(ring[i], alu_op[k], 1'b0);
        checks++;
        if (con !== alu_con[k][i]) begin
          errors++; $display("FAIL op%b_con_T%0d: got %h expected %h", alu_op[k], i + 1, con, alu_con[k][i]);
        end
        tick;
      end
      checks++;
      if (instr_cnt !== 8'(k + 2)) begin errors++; $display("FAIL op%b_cnt: got %0d expected %0d", alu_op[k], instr_cnt, k + 2); end
    end
    checks++;
    if (state_err !== 1'b0) begin errors++; $display("FAIL alu_err: got %b expected 0", state_err); end
  endtask

  task automatic test_hlt;
    for (int i = 0; i < 4; i++) begin
      drive(ring[i], 4'b1111, 1'b0);
      checks++;
      if (con !== ((i < 3) ? lda_con[i] : 12'h000)) begin
        errors++; $display("FAIL hlt_con_T%0d: got %h expected %h", i + 1, con, (i < 3) ? lda_con[i] : 12'h000);
      end
      tick;
      checks++;
      if (hlt !== (i == 3)) begin errors++; $display("FAIL hlt_flag_T%0d: got %b expected %b", i + 1, hlt, i == 3); end
    end
    for (int n = 0; n < 10; n++) begin
      drive(ring[(n + 4) % 6], (n % 2 == 0) ? 4'b0001 : 4'b1111, 1'b0);
      checks++;
      if (con !== 12'h000) begin errors++; $display("FAIL halted_con_%0d: got %h expected 000", n, con); end
      tick;
    end
    checks++;
    if ({hlt, state_err, instr_cnt} !== {1'b1, 1'b0, 8'd5}) begin
      errors++; $display("FAIL halted_regs: got hlt=%b err=%b cnt=%0d expected 1 0 5", hlt, state_err, instr_cnt);
    end
    drive(6'b000100, 4'b0000, 1'b1);
    tick;
    checks++;
    if ({hlt, instr_cnt} !== 9'd0) begin errors++; $display("FAIL hlt_clr: got hlt=%b cnt=%0d expected 0 0", hlt, instr_cnt); end
  endtask

  task automatic test_checker;
    drive(6'b000001, 4'b0000, 1'b0);
    tick;
    drive(6'b000011, 4'b0000, 1'b0);
    checks++;
    if (con !== 12'h000) begin errors++; $display("FAIL bad_onehot_con: got %h expected 000", con); end
    tick;
    checks++;
    if (state_err !== 1'b1) begin errors++; $display("FAIL bad_onehot_err: got %b expected 1", state_err); end
    for (int i = 0; i < 3; i++) begin
      drive(ring[i], 4'b0000, 1'b0);
      tick;
    end
    checks++;
    if (state_err !== 1'b1) begin errors++; $display("FAIL onehot_sticky: got %b expected 1", state_err); end
    drive(6'b000001, 4'b0000, 1'b1);
    tick;
    checks++;
    if (state_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b expected 0", state_err); end
    drive(6'b000001, 4'b0000, 1'b0);
    tick;
    drive(6'b000010, 4'b0000, 1'b0);
    tick;
    checks++;
    if (state_err !== 1'b0) begin errors++; $display("FAIL skip_pre: got %b expected 0", state_err); end
    drive(6'b001000, 4'b0000, 1'b0);
    tick;
    checks++;
    if (state_err !== 1'b1) begin errors++; $display("FAIL skip_err: got %b expected 1", state_err); end
    drive(6'b010000, 4'b0000, 1'b0);
    tick;
    drive(6'b100000, 4'b0000, 1'b0);
    tick;
    checks++;
    if (state_err !== 1'b1) begin errors++; $display("FAIL skip_sticky: got %b expected 1", state_err); end
  endtask

  // T4 -> T6 is a broken rotation that still lands on T6: both effects must occur.
  task automatic test_t6_err;
    drive(6'b000001, 4'b0000, 1'b1);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(ring[i], 4'b0000, 1'b0);
      tick;
    end
    drive(6'b100000, 4'b0000, 1'b0);
    tick;
    checks++;
    if ({state_err, instr_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL t6_err: got err=%b cnt=%0d expected 1 1", state_err, instr_cnt);
    end
  endtask

  task automatic test_saturation;
    drive(6'b000001, 4'b0000, 1'b1);
    tick;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 6; i++) begin
        drive(ring[i], 4'b0000, 1'b0);
        tick;
      end
      checks++;
      if (cnt2 !== 2'((k > 3) ? 3 : k)) begin
        errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, cnt2, (k > 3) ? 3 : k);
      end
    end
    checks++;
    if (instr_cnt !== 8'd5) begin errors++; $display("FAIL wide_cnt: got %0d expected 5", instr_cnt); end
    for (int i = 0; i < 4; i++) begin
      drive(ring[i], 4'b0001, 1'b0);
      tick;
    end
    drive(6'b010000, 4'b0001, 1'b1);
    checks++;
    if (con2 !== 12'h000) begin errors++; $display("FAIL midclr_con: got %h expected 000", con2); end
    tick;
    checks++;
    if ({hlt2, state_err2, cnt2, instr_cnt} !== 12'd0) begin
      errors++; $display("FAIL midclr_regs: got hlt=%b err=%b cnt2=%0d cnt=%0d expected all 0", hlt2, state_err2, cnt2, instr_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive(ring[i], 4'b0000, 1'b0);
      checks++;
      if (con2 !== lda_con[i]) begin errors++; $display("FAIL restart_con_T%0d: got %h expected %h", i + 1, con2, lda_con[i]); end
      tick;
    end
    checks++;
    if ({state_err2, cnt2} !== {1'b0, 2'd1}) begin
      errors++; $display("FAIL restart_regs: got err=%b cnt2=%0d expected 0 1", state_err2, cnt2);
    end
  endtask

  initial begin
    clr = 1'b1;
    State = 6'b100000;
    opcode = 4'b0000;
    test_reset;
    test_lda;
    test_alu_ops;
    test_hlt;
    test_checker;
    test_t6_err;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
